// File: rtl/app_output_arbiter_if.sv
// app_output_arbiter_if: selection, application channels and board outputs of the output arbiter.
interface app_output_arbiter_if #(
    parameter int NUM_APPS = 4,
    parameter int SEL_W = 2
);
    logic sel_valid;
    logic [SEL_W-1:0] sel_req;
    logic frame_sync;
    logic [15:0] idle_led;
    logic [NUM_APPS*16-1:0] app_led;
    logic [NUM_APPS*8-1:0] app_seg;
    logic [NUM_APPS*4-1:0] app_an;
    logic [NUM_APPS*16-1:0] app_oled;
    logic [15:0] led;
    logic [7:0] seg;
    logic [3:0] an;
    logic [15:0] oled_data;
    logic [NUM_APPS-1:0] app_enable;
    logic switching;
    modport master(
        output sel_valid, sel_req, frame_sync, idle_led, app_led, app_seg, app_an, app_oled,
        input led, seg, an, oled_data, app_enable, switching
    );
    modport slave(
        input sel_valid, sel_req, frame_sync, idle_led, app_led, app_seg, app_an, app_oled,
        output led, seg, an, oled_data, app_enable, switching
    );
endinterface

// File: rtl/app_output_arbiter.sv
// app_output_arbiter: debounced application select with frame-aligned OLED hand-over.
// Optional macro APP_ARB_IDLE_BANNER_EN scans a "----" banner on seg/an while idle.
module app_output_arbiter #(
    parameter int NUM_APPS = 4,
    parameter int SEL_W = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int BLANK_FRAMES = 2
) (
    input logic clock_100mhz,
    input logic reset,
    app_output_arbiter_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int BW = BLANK_FRAMES > 0 ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam int LAST_I = STABLE_CYCLES > 1 ? STABLE_CYCLES - 2 : 0;
    localparam int BLOAD_I = BLANK_FRAMES;
    localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
    localparam logic [BW-1:0] BLOAD = BLOAD_I[BW-1:0];
    localparam logic [SEL_W:0] NA = NUM_APPS[SEL_W:0];
    // Selections are {valid, index}; idle is all zeros so whole-vector compares work.
    localparam logic [SEL_W:0] IDLE = '0;

    typedef enum logic [1:0] {STEADY, WAIT_FRAME, BLANK} ostate_t;

    logic [SEL_W:0] req, cand, cur, cand_nxt, cur_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic commit;
    logic [SEL_W-1:0] idx;
    logic [7:0] idle_seg;
    logic [3:0] idle_an;
    ostate_t state, state_nxt;
    logic [SEL_W:0] oled_cur, oled_cur_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [15:0] oled_nxt;

    assign req = (bus.sel_valid && {1'b0, bus.sel_req} < NA) ? {1'b1, bus.sel_req} : IDLE;
    assign idx = cur[SEL_W-1:0];

    // The cycle a request first appears already counts towards its hold time.
    always_comb begin
        cand_nxt = req;
        cnt_nxt = '0;
        commit = 1'b0;
        if (req != cand) begin
            commit = STABLE_CYCLES == 1 && req != cur;
        end else if (cand != cur) begin
            commit = cnt == LAST;
            cnt_nxt = commit ? '0 : cnt + 1'b1;
        end
        cur_nxt = commit ? req : cur;
    end

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            cand <= IDLE;
            cur <= IDLE;
            cnt <= '0;
        end else begin
            cand <= cand_nxt;
            cur <= cur_nxt;
            cnt <= cnt_nxt;
        end
    end

`ifdef APP_ARB_IDLE_BANNER_EN
    logic [17:0] ban_cnt;
    logic [1:0] dig;
    always_ff @(posedge clock_100mhz) begin
        if (reset || commit) begin
            ban_cnt <= '0;
            dig <= '0;
        end else begin
            ban_cnt <= ban_cnt + 1'b1;
            dig <= dig + 2'(&ban_cnt);
        end
    end
    assign idle_seg = 8'hBF;
    assign idle_an = ~(4'b0001 << dig);
`else
    assign idle_seg = 8'hFF;
    assign idle_an = 4'hF;
`endif

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            bus.led <= '0;
            bus.seg <= 8'hFF;
            bus.an <= 4'hF;
            bus.app_enable <= '0;
        end else begin
            bus.led <= cur[SEL_W] ? bus.app_led[16*idx +: 16] : bus.idle_led;
            bus.seg <= cur[SEL_W] ? bus.app_seg[8*idx +: 8] : idle_seg;
            bus.an <= cur[SEL_W] ? bus.app_an[4*idx +: 4] : idle_an;
            bus.app_enable <= cur[SEL_W] ? NUM_APPS'(1) << idx : '0;
        end
    end

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            state <= STEADY;
            oled_cur <= IDLE;
            bcnt <= '0;
            bus.oled_data <= '0;
        end else begin
            state <= state_nxt;
            oled_cur <= oled_cur_nxt;
            bcnt <= bcnt_nxt;
            bus.oled_data <= oled_nxt;
        end
    end

    // A commit takes priority over a coincident frame_sync, which is then left unused.
    always_comb begin
        state_nxt = state;
        oled_cur_nxt = oled_cur;
        bcnt_nxt = bcnt;
        case (state)
            STEADY: if (commit) state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (bus.frame_sync) begin
                oled_cur_nxt = cur_nxt;
                bcnt_nxt = BLOAD;
                if (BLANK_FRAMES == 0) state_nxt = STEADY;
                else state_nxt = BLANK;
            end
            BLANK: if (commit) state_nxt = WAIT_FRAME;
            else if (bus.frame_sync) begin
                bcnt_nxt = bcnt - 1'b1;
                if (bcnt_nxt == '0) state_nxt = STEADY;
            end
            default: state_nxt = STEADY;
        endcase
    end

    always_comb begin
        oled_nxt = (state == BLANK || !oled_cur[SEL_W]) ? 16'h0 : bus.app_oled[16*oled_cur[SEL_W-1:0] +: 16];
    end

    assign bus.switching = state != STEADY;
endmodule

// File: tb/tb_app_output_arbiter.sv
// tb_app_output_arbiter: directed scoreboard bench for app_output_arbiter.
module tb_app_output_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    string tag_q[$];

    app_output_arbiter_if #(.NUM_APPS(4), .SEL_W(2)) a ();
    app_output_arbiter_if #(.NUM_APPS(3), .SEL_W(2)) b ();

    app_output_arbiter #(.NUM_APPS(4), .SEL_W(2), .STABLE_CYCLES(4), .BLANK_FRAMES(2)) dut (
        .clock_100mhz(clk), .reset(rst), .bus(a.slave)
    );
    app_output_arbiter #(.NUM_APPS(3), .SEL_W(2), .STABLE_CYCLES(4), .BLANK_FRAMES(2)) dut3 (
        .clock_100mhz(clk), .reset(rst), .bus(b.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty obs=%0h exp=none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", t, obs, e);
        end
    endtask

    task automatic pulse();
        a.frame_sync = 1'b1;
        tick(1);
        a.frame_sync = 1'b0;
        tick(2);
    endtask

    initial begin
        a.sel_valid = 1'b0;
        a.sel_req = 2'd0;
        a.frame_sync = 1'b0;
        a.idle_led = 16'h00FF;
        a.app_led = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        a.app_seg = {8'h44, 8'h33, 8'h22, 8'h11};
        a.app_an = {4'h4, 4'h3, 4'h2, 4'h1};
        a.app_oled = {16'h0F0F, 16'hF800, 16'h07E0, 16'h001F};
        b.sel_valid = 1'b0;
        b.sel_req = 2'd0;
        b.frame_sync = 1'b0;
        b.idle_led = 16'h00FF;
        b.app_led = {16'h3333, 16'h2222, 16'h1111};
        b.app_seg = {8'h33, 8'h22, 8'h11};
        b.app_an = {4'h3, 4'h2, 4'h1};
        b.app_oled = {16'h0003, 16'h0002, 16'h0001};
        expect_val("rst_led", 32'h0);
        expect_val("rst_seg", 32'hFF);
        expect_val("rst_an", 32'hF);
        expect_val("rst_oled", 32'h0);
        expect_val("rst_enable", 32'h0);
        expect_val("rst_switching", 32'h0);
        tick(3);
        check(a.led);
        check(a.seg);
        check(a.an);
        check(a.oled_data);
        check(a.app_enable);
        check(a.switching);
        rst = 1'b0;

        a.sel_valid = 1'b1;
        a.sel_req = 2'd2;
        expect_val("early_enable", 32'h0);
        tick(3);
        check(a.app_enable);
        expect_val("commit_led", 32'hA5A5);
        expect_val("commit_seg", 32'h33);
        expect_val("commit_an", 32'h3);
        expect_val("commit_enable", 32'h4);
        expect_val("commit_oled", 32'h0);
        expect_val("commit_switching", 32'h1);
        tick(2);
        check(a.led);
        check(a.seg);
        check(a.an);
        check(a.app_enable);
        check(a.oled_data);
        check(a.switching);

        expect_val("blank1_oled", 32'h0);
        expect_val("blank1_switching", 32'h1);
        pulse();
        check(a.oled_data);
        check(a.switching);
        expect_val("blank2_switching", 32'h1);
        pulse();
        check(a.switching);
        expect_val("handover_switching", 32'h0);
        expect_val("handover_oled", 32'hF800);
        pulse();
        check(a.switching);
        check(a.oled_data);

        expect_val("bounce_enable", 32'h4);
        expect_val("bounce_led", 32'hA5A5);
        expect_val("bounce_switching", 32'h0);
        for (int i = 0; i < 20; i++) begin
            a.sel_req = (i % 2 == 0) ? 2'd1 : 2'd2;
            tick(2);
        end
        check(a.app_enable);
        check(a.led);
        check(a.switching);

        expect_val("collide_switching", 32'h1);
        a.sel_req = 2'd1;
        tick(3);
        a.frame_sync = 1'b1;
        tick(1);
        a.frame_sync = 1'b0;
        check(a.switching);
        expect_val("collide_led", 32'h2222);
        expect_val("collide_enable", 32'h2);
        expect_val("collide_oled_held", 32'hF800);
        tick(1);
        check(a.led);
        check(a.app_enable);
        check(a.oled_data);
        expect_val("collide_blank_oled", 32'h0);
        expect_val("collide_blank_switching", 32'h1);
        pulse();
        check(a.oled_data);
        check(a.switching);
        expect_val("collide_blank2_switching", 32'h1);
        pulse();
        check(a.switching);
        expect_val("collide_done_oled", 32'h07E0);
        expect_val("collide_done_switching", 32'h0);
        pulse();
        check(a.oled_data);
        check(a.switching);

        a.sel_valid = 1'b0;
        expect_val("idle_led", 32'h00FF);
        expect_val("idle_seg", 32'hFF);
        expect_val("idle_an", 32'hF);
        expect_val("idle_enable", 32'h0);
        expect_val("idle_switching", 32'h1);
        tick(5);
        check(a.led);
        check(a.seg);
        check(a.an);
        check(a.app_enable);
        check(a.switching);
        expect_val("idle_settled_switching", 32'h0);
        expect_val("idle_settled_oled", 32'h0);
        for (int i = 0; i < 5 && a.switching; i++) pulse();
        check(a.switching);
        check(a.oled_data);

        b.sel_valid = 1'b1;
        b.sel_req = 2'd0;
        expect_val("n3_led", 32'h1111);
        expect_val("n3_enable", 32'h1);
        tick(5);
        check(b.led);
        check(b.app_enable);
        b.sel_req = 2'd3;
        expect_val("n3_range_led", 32'h00FF);
        expect_val("n3_range_enable", 32'h0);
        expect_val("n3_range_seg", 32'hFF);
        tick(5);
        check(b.led);
        check(b.app_enable);
        check(b.seg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
